// File: rtl/select8_pkg.sv
// Shared widths, block-count helper and sum type for the select8 carry-select adder.
package select8_pkg;
  localparam int WIDTH_DEF   = 8;
  localparam int BLOCK_W_DEF = 4;

  typedef logic [WIDTH_DEF-1:0] sum_t;

  function automatic int num_blocks(input int width, input int block_w);
    return width / block_w;
  endfunction
endpackage

// File: rtl/select8_if.sv
// Operand/result bundle for select8_adder: producer drives master, adder is slave.
interface select8_if import select8_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF
);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             in_valid;
  logic [WIDTH-1:0] S;
  logic             Cout;
  logic             out_valid;

  modport master (output A, B, Cin, in_valid, input  S, Cout, out_valid);
  modport slave  (input  A, B, Cin, in_valid, output S, Cout, out_valid);
endinterface

// File: rtl/select8_ripple_block.sv
// BLOCK_W-bit ripple-carry adder built from explicit full-adder cells.
module select8_ripple_block import select8_pkg::*; #(
  parameter int BLOCK_W = BLOCK_W_DEF
) (
  input  logic [BLOCK_W-1:0] a,
  input  logic [BLOCK_W-1:0] b,
  input  logic               ci,
  output logic [BLOCK_W-1:0] s,
  output logic               co
);
  logic [BLOCK_W:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < BLOCK_W; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign co = c[BLOCK_W];
endmodule

// File: rtl/select8_adder.sv
// Carry-select adder with a 1-cycle registered output stage.
// Define SELECT8_BYPASS_REG_EN to drop the output register (combinational, clk/rst unused).
module select8_adder import select8_pkg::*; #(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int BLOCK_W = BLOCK_W_DEF
) (
  input  logic     clk,
  input  logic     rst,
  select8_if.slave bus
);
  localparam int NB = num_blocks(WIDTH, BLOCK_W);

  logic [NB:0]                 blk_c;
  logic [NB-1:0][BLOCK_W-1:0]  sum_c;
  logic [WIDTH-1:0]            sum_d;
  logic                        cout_d;

  assign blk_c[0] = bus.Cin;

  select8_ripple_block #(.BLOCK_W(BLOCK_W)) u_blk0 (
    .a  (bus.A[BLOCK_W-1:0]),
    .b  (bus.B[BLOCK_W-1:0]),
    .ci (blk_c[0]),
    .s  (sum_c[0]),
    .co (blk_c[1])
  );

  // Upper blocks: both carry-in hypotheses computed in parallel, picked by the lower block's carry.
  for (genvar k = 1; k < NB; k++) begin : g_sel
    logic [BLOCK_W-1:0] s0, s1;
    logic               c0, c1;

    select8_ripple_block #(.BLOCK_W(BLOCK_W)) u_ci0 (
      .a  (bus.A[k*BLOCK_W +: BLOCK_W]),
      .b  (bus.B[k*BLOCK_W +: BLOCK_W]),
      .ci (1'b0),
      .s  (s0),
      .co (c0)
    );

    select8_ripple_block #(.BLOCK_W(BLOCK_W)) u_ci1 (
      .a  (bus.A[k*BLOCK_W +: BLOCK_W]),
      .b  (bus.B[k*BLOCK_W +: BLOCK_W]),
      .ci (1'b1),
      .s  (s1),
      .co (c1)
    );

    assign sum_c[k]   = blk_c[k] ? s1 : s0;
    assign blk_c[k+1] = blk_c[k] ? c1 : c0;
  end

  assign sum_d  = sum_c;
  assign cout_d = blk_c[NB];

`ifdef SELECT8_BYPASS_REG_EN
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst;

  assign bus.S         = sum_d;
  assign bus.Cout      = cout_d;
  assign bus.out_valid = bus.in_valid;
`else
  logic [WIDTH-1:0] s_q;
  logic             cout_q;
  logic             vld_q;

  // Data registers load every cycle; only the valid bit qualifies them.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_q    <= '0;
      cout_q <= 1'b0;
      vld_q  <= 1'b0;
    end else begin
      s_q    <= sum_d;
      cout_q <= cout_d;
      vld_q  <= bus.in_valid;
    end
  end

  assign bus.S         = s_q;
  assign bus.Cout      = cout_q;
  assign bus.out_valid = vld_q;
`endif
endmodule

// File: tb/tb_select8_adder.sv
// Directed + swept scoreboard bench for select8_adder (registered build).
module tb_select8_adder;
  logic clk;
  logic rst;

  select8_if #(.WIDTH(8)) bus ();

  select8_adder #(.WIDTH(8), .BLOCK_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       vld;
    logic [7:0] s;
    logic       co;
  } exp_t;

  exp_t sb[$];
  int   passed = 0;
  int   failed = 0;
  int   total  = 0;

  task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one input beat, record its expected outcome, then check after the edge.
  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic cin,
                       input logic v, input logic r, input string tag);
    exp_t e;
    bus.A        = a;
    bus.B        = b;
    bus.Cin      = cin;
    bus.in_valid = v;
    rst          = r;
    e.rst = r;
    e.vld = v & ~r;
    {e.co, e.s} = 9'(a) + 9'(b) + 9'(cin);
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check({tag, "/sb_empty"}, 9'd1, 9'd0);
    end else begin
      e = sb.pop_front();
      if (e.rst) begin
        check({tag, "/vld"}, {8'd0, bus.out_valid}, 9'd0);
        check({tag, "/sum"}, {bus.Cout, bus.S}, 9'd0);
      end else if (e.vld) begin
        check({tag, "/vld"}, {8'd0, bus.out_valid}, 9'd1);
        check({tag, "/sum"}, {bus.Cout, bus.S}, {e.co, e.s});
      end else begin
        check({tag, "/vld"}, {8'd0, bus.out_valid}, 9'd0);
      end
    end
  endtask

  initial begin
    logic [7:0] bset [16];
    bset = '{8'h00, 8'h01, 8'h0F, 8'h10, 8'h11, 8'h7F, 8'h80, 8'hF0,
             8'hFF, 8'hAA, 8'h55, 8'h3C, 8'hC3, 8'h0E, 8'hEF, 8'h8F};
    rst          = 1'b1;
    bus.A        = '0;
    bus.B        = '0;
    bus.Cin      = 1'b0;
    bus.in_valid = 1'b0;

    drive(8'hAA, 8'h55, 1'b1, 1'b1, 1'b1, "reset0");
    drive(8'hAA, 8'h55, 1'b1, 1'b1, 1'b1, "reset1");

    drive(8'h0F, 8'h01, 1'b0, 1'b1, 1'b0, "blk_carry");
    drive(8'hFF, 8'h00, 1'b1, 1'b1, 1'b0, "full_prop");
    drive(8'hFF, 8'hFF, 1'b1, 1'b1, 1'b0, "max_ops");
    drive(8'h80, 8'h80, 1'b0, 1'b1, 1'b0, "msb_ovf");
    drive(8'hxx, 8'hxx, 1'bx, 1'b0, 1'b0, "idle_x");
    drive(8'h12, 8'h34, 1'b1, 1'b1, 1'b0, "after_x");

    for (int i = 1; i <= 3; i++) drive(8'(i), 8'h01, 1'b0, 1'b1, 1'b0, "stream");
    drive(8'h04, 8'h01, 1'b0, 1'b1, 1'b1, "mid_rst");
    drive(8'h04, 8'h01, 1'b0, 1'b1, 1'b0, "resume4");
    drive(8'h05, 8'h01, 1'b0, 1'b1, 1'b0, "resume5");

    // Every A against a set of carry-pattern B values, both carry-ins, back to back.
    for (int bi = 0; bi < 16; bi++)
      for (int a = 0; a < 256; a++)
        for (int c = 0; c < 2; c++)
          drive(8'(a), bset[bi], 1'(c), 1'b1, 1'b0, "sweep");

    for (int n = 0; n < 3000; n++)
      drive(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0), 1'b0, "random");

    drive(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, "drain");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
